// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-path definitions: FSM encodings and default datapath widths
// (the widths are also used by pc_counter).
package instr_fetch_unit_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 32;
  localparam int unsigned INSTR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small register FIFO holding fetched {pc, instr} pairs; flush empties it
// and takes priority over push and pop.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];
  assign push_s    = push && !full;
  assign pop_s     = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/instr_fetch_unit_chk.sv
// Simulation-side protocol checks for the fetch unit: unexpected memory
// responses and FIFO overflow.
module instr_fetch_unit_chk (
  input logic clk,
  input logic rst_n,
  input logic req_fire,
  input logic rsp_valid,
  input logic rsp_expected,
  input logic push,
  input logic full
);

  logic seen_req_r;

  // Responses left over from before a reset are tolerated until a new request goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_req_r <= 1'b0;
    else if (req_fire) seen_req_r <= 1'b1;
  end

  // Protocol checks sampled on the active edge.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(seen_req_r && rsp_valid && !rsp_expected))
        else $error("imem response with no request outstanding");
      assert (!(push && full))
        else $error("fetch fifo push while full");
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts PCs, issues one outstanding memory read at
// a time, buffers results for decode, and drops wrong-path work on redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic                   pc_valid,
  output logic                   pc_ready,
  input  logic                   redirect,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [INSTR_WIDTH-1:0] dec_instr,
  output logic [PC_WIDTH-1:0]    dec_pc
);

  localparam int unsigned EW = PC_WIDTH + INSTR_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e        state_r;
  fetch_state_e        state_nx_s;
  logic [PC_WIDTH-1:0] addr_r;
  logic                flush_pend_r;
  logic                flush_pend_nx_s;
  logic                ready_en_r;
  logic                accept_s;
  logic                push_s;
  logic [EW-1:0]       head_s;
  logic [CW-1:0]       fifo_count_s;
  logic                fifo_empty_s;
  logic                fifo_full_s;

  // Next state, PC acceptance and FIFO push decisions.
  always_comb begin
    state_nx_s      = state_r;
    flush_pend_nx_s = flush_pend_r;
    pc_ready        = 1'b0;
    accept_s        = 1'b0;
    push_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A slot must be free before a PC is taken, so the later push cannot overflow.
        pc_ready = ready_en_r && !redirect && (fifo_count_s < CW'(FIFO_DEPTH));
        accept_s = pc_valid && pc_ready;
        if (accept_s) state_nx_s = ST_REQ;
        else state_nx_s = ST_IDLE;
      end
      ST_REQ: begin
        if (imem_req_ready) begin
          state_nx_s      = (redirect || flush_pend_r) ? ST_DROP : ST_WAIT;
          flush_pend_nx_s = 1'b0;
        end else begin
          flush_pend_nx_s = flush_pend_r || redirect;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          push_s     = !redirect;
          state_nx_s = ST_IDLE;
        end else if (redirect) begin
          state_nx_s = ST_DROP;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) state_nx_s = ST_IDLE;
        else state_nx_s = ST_DROP;
      end
      default: begin
        state_nx_s      = ST_IDLE;
        flush_pend_nx_s = 1'b0;
      end
    endcase
  end

  // FSM, request address and sticky flush registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      addr_r       <= {PC_WIDTH{1'b0}};
      flush_pend_r <= 1'b0;
      ready_en_r   <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      flush_pend_r <= flush_pend_nx_s;
      ready_en_r   <= 1'b1;
      if (accept_s) addr_r <= pc_in;
    end
  end

  assign imem_req_valid = (state_r == ST_REQ);
  assign imem_req_addr  = addr_r;
  assign dec_valid      = !fifo_empty_s;
  assign dec_pc         = head_s[EW-1:INSTR_WIDTH];
  assign dec_instr      = head_s[INSTR_WIDTH-1:0];

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data ({addr_r, imem_rsp_data}),
    .pop       (dec_ready),
    .flush     (redirect),
    .head_data (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  instr_fetch_unit_chk u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_fire     (imem_req_valid && imem_req_ready),
    .rsp_valid    (imem_rsp_valid),
    .rsp_expected ((state_r == ST_WAIT) || (state_r == ST_DROP)),
    .push         (push_s),
    .full         (fifo_full_s)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct packed {
    int          due;
    logic [31:0] addr;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_in = 32'h0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        redirect = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  // reference model state: fetched-but-unconsumed instructions and the one fetch in flight
  exp_t        exp_q[$];
  bit          pend_valid = 1'b0;
  bit          pend_taint = 1'b0;
  bit          req_done = 1'b0;
  bit          ready_en = 1'b0;
  logic [31:0] pend_pc = 32'h0;

  // memory model
  mem_t        mem_q[$];
  int          cyc = 0;
  int          mem_lat = 1;
  bit          mem_hs = 1'b0;
  logic [31:0] mem_hs_addr = 32'h0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .redirect(redirect), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    bit ok;
    ok = 1'b0;
    pc_in    = pc;
    pc_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (pc_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fetch_accept: pc %h not accepted within 40 cycles", pc);
    end
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
  endtask

  // Memory: one response per accepted request, mem_lat edges later (0 = random 1..3).
  always @(posedge clk) begin
    mem_t m;
    #1;
    cyc++;
    if (mem_hs) begin
      m.due  = cyc + ((mem_lat != 0) ? mem_lat : int'($urandom_range(1, 3)));
      m.addr = mem_hs_addr;
      mem_q.push_back(m);
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  end

  // Level checks against the model, sampled mid-cycle; also records memory handshakes.
  always @(negedge clk) begin
    mem_hs      = rst_n && imem_req_valid && imem_req_ready;
    mem_hs_addr = imem_req_addr;
    if (!rst_n) begin
      checks++;
      if (pc_ready !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 ||
          dec_valid !== 1'b0 || dec_instr !== 32'h0 || dec_pc !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: pc_ready=%b req_valid=%b addr=%h dec_valid=%b instr=%h pc=%h, all required 0",
                 pc_ready, imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc);
      end
    end else begin
      check_bit("dec_valid", dec_valid, exp_q.size() != 0);
      check_bit("pc_ready", pc_ready, ready_en && !pend_valid && !redirect && (exp_q.size() < DEPTH));
      check_bit("req_valid", imem_req_valid, pend_valid && !req_done);
      if (pend_valid && !req_done) check_word("req_addr", imem_req_addr, pend_pc);
    end
  end

  // Scoreboard monitor: compare the presented head, pop on consumption.
  always @(negedge clk) begin
    #1;
    if (rst_n && dec_valid && exp_q.size() != 0) begin
      check_word("dec_pc", dec_pc, exp_q[0].pc);
      check_word("dec_instr", dec_instr, exp_q[0].instr);
      if (dec_ready && !redirect) begin
        void'(exp_q.pop_front());
        delivered++;
      end
    end
  end

  // Model update for the coming edge: fetches survive only if no redirect
  // falls between acceptance and response; redirect empties the buffer.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      exp_q.delete();
      pend_valid = 1'b0;
      pend_taint = 1'b0;
      req_done   = 1'b0;
      ready_en   = 1'b0;
    end else begin
      if (imem_rsp_valid && pend_valid && req_done) begin
        if (!pend_taint && !redirect) begin
          e.pc    = pend_pc;
          e.instr = mem_word(pend_pc);
          exp_q.push_back(e);
        end
        pend_valid = 1'b0;
      end
      if (redirect) begin
        exp_q.delete();
        pend_taint = 1'b1;
      end
      if (pend_valid && !req_done && imem_req_ready) req_done = 1'b1;
      if (pc_valid && pc_ready) begin
        pend_valid = 1'b1;
        pend_pc    = pc_in;
        pend_taint = 1'b0;
        req_done   = 1'b0;
      end
      ready_en = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    #1 rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);

    // basic fetch and minimum latency
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    fetch(32'h0);
    @(negedge clk);
    @(negedge clk);
    check_bit("lat_t2_dec_valid", dec_valid, 1'b0);
    @(negedge clk);
    check_bit("lat_t3_dec_valid", dec_valid, 1'b1);
    check_word("lat_t3_instr", dec_instr, 32'h0050_0093);
    check_word("lat_t3_pc", dec_pc, 32'h0);
    @(posedge clk);
    #1;
    cycles(2);

    // decode back-pressure
    dec_ready = 1'b0;
    fetch(32'h0);
    fetch(32'h4);
    pc_in    = 32'h8;
    pc_valid = 1'b1;
    cycles(8);
    @(negedge clk);
    check_bit("bp_pc_ready", pc_ready, 1'b0);
    check_bit("bp_dec_valid", dec_valid, 1'b1);
    @(posedge clk);
    #1;
    dec_ready = 1'b1;
    cycles(1);
    dec_ready = 1'b0;
    fetch(32'h8);
    dec_ready = 1'b1;
    cycles(6);

    // memory stall
    imem_req_ready = 1'b0;
    fetch(32'h10);
    pc_in    = 32'h14;
    pc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("stall_req_valid", imem_req_valid, 1'b1);
      check_word("stall_req_addr", imem_req_addr, 32'h10);
      check_bit("stall_pc_ready", pc_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    pc_valid       = 1'b0;
    imem_req_ready = 1'b1;
    cycles(5);

    // redirect while waiting for memory
    mem_lat = 4;
    fetch(32'h20);
    cycles(1);
    redirect = 1'b1;
    cycles(2);
    redirect = 1'b0;
    mem_lat  = 1;
    fetch(32'h30);
    cycles(6);

    // redirect with a full buffer and a simultaneous pop
    dec_ready = 1'b0;
    fetch(32'h40);
    fetch(32'h44);
    cycles(4);
    @(negedge clk);
    check_bit("full_dec_valid", dec_valid, 1'b1);
    @(posedge clk);
    #1;
    redirect  = 1'b1;
    dec_ready = 1'b1;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    check_bit("flush_dec_valid", dec_valid, 1'b0);
    cycles(3);

    // async reset in REQ
    imem_req_ready = 1'b0;
    fetch(32'h50);
    cycles(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("arst_req_valid", imem_req_valid, 1'b0);
    check_bit("arst_pc_ready", pc_ready, 1'b0);
    check_word("arst_req_addr", imem_req_addr, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    cycles(2);

    // async reset in WAIT; the late response must not reach decode
    mem_lat = 6;
    fetch(32'h60);
    cycles(2);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit("late_rsp_dec_valid", dec_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    mem_lat = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r              = $urandom;
      pc_in          = {r[31:2], 2'b00};
      pc_valid       = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      dec_ready      = ($urandom_range(0, 9) < 6);
      redirect       = ($urandom_range(0, 19) == 0);
      cycles(1);
    end

    // drain
    pc_valid       = 1'b0;
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    cycles(20);
    @(negedge clk);
    check_bit("drain_dec_valid", dec_valid, 1'b0);
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL delivered_count: got %0d instructions, required at least 100", delivered);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
